// File: rtl/dff_response_checker.sv
// rtl/dff_response_checker.sv - checks q against d delayed LATENCY clocks and qn against ~q
// Counts samples and mismatches per window and reports pass/fail.
module dff_response_checker #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             d_stim,
  input  logic             q_obs,
  input  logic             qn_obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  localparam logic [2:0]       FILL_LAST = 3'(LATENCY > 1 ? LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t             state;
  logic [LATENCY-1:0] dly;
  logic [2:0]         fill_cnt;
  logic               expected;
  logic               mismatch;

  assign expected = dly[LATENCY-1];
  assign mismatch = (q_obs != expected) || (qn_obs == q_obs);

  assign busy = (state == FILL) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0) && (sample_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dly           <= '0;
      fill_cnt      <= '0;
      err_pulse     <= 1'b0;
      err_count     <= '0;
      sample_count  <= '0;
      first_err_idx <= '0;
    end else begin
      // The delay line runs in every state so it is primed by the time FILL ends.
      dly[0] <= d_stim;
      for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
      err_pulse <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= (LATENCY == 1) ? CHECK : FILL;
            fill_cnt      <= '0;
            err_count     <= '0;
            sample_count  <= '0;
            first_err_idx <= '0;
          end
        end
        FILL: begin
          if (stop)                       state    <= DONE;
          else if (fill_cnt == FILL_LAST) state    <= CHECK;
          else                            fill_cnt <= fill_cnt + 3'd1;
        end
        CHECK: begin
          if (stop) begin
            state <= DONE;
          end else begin
            if (sample_count != CNT_MAX) sample_count <= sample_count + 1'b1;
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
              // err_count never wraps back to zero, so this marks the first error only.
              if (err_count == '0) first_err_idx <= sample_count;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_response_checker.sv
// tb/tb_dff_response_checker.sv - directed self-checking bench for dff_response_checker
module tb_dff_response_checker;

  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, stop = 1'b0, d = 1'b0;

  // Reference flip-flop models standing in for the DUT under observation
  logic ff1 = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   mode = 0;
  logic inj  = 1'b0;

  logic q0, qn0, q1, qn1, q2, qn2;
  assign q0  = (mode == 1) ? 1'b0 : ff1;
  assign qn0 = inj ? q0 : ~q0;
  assign q1  = ff1;
  assign qn1 = ff1;
  assign q2  = s3;
  assign qn2 = ~s3;

  logic        busy0, done0, pass0, ep0;
  logic [15:0] ec0, sc0, fe0;
  logic        busy1, done1, pass1, ep1;
  logic [3:0]  ec1, sc1, fe1;
  logic        busy2, done2, pass2, ep2;
  logic [15:0] ec2, sc2, fe2;

  int n_vec = 0, n_mis = 0, pulses = 0;
  logic [15:0] pat6 = 16'hB38D;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ff1 <= d;
    s1  <= d;
    s2  <= s1;
    s3  <= s2;
  end

  dff_response_checker #(.LATENCY(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .d_stim(d), .q_obs(q0), .qn_obs(qn0),
    .busy(busy0), .done(done0), .pass(pass0), .err_pulse(ep0),
    .err_count(ec0), .sample_count(sc0), .first_err_idx(fe0));

  dff_response_checker #(.LATENCY(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .d_stim(d), .q_obs(q1), .qn_obs(qn1),
    .busy(busy1), .done(done1), .pass(pass1), .err_pulse(ep1),
    .err_count(ec1), .sample_count(sc1), .first_err_idx(fe1));

  dff_response_checker #(.LATENCY(3), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .d_stim(d), .q_obs(q2), .qn_obs(qn2),
    .busy(busy2), .done(done2), .pass(pass2), .err_pulse(ep2),
    .err_count(ec2), .sample_count(sc2), .first_err_idx(fe2));

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ep0) pulses++;
  endtask

  // Start, eight alternating samples (1,0,1,0,...), then stop on the following edge.
  task automatic run_window(input int m);
    mode   = m;
    pulses = 0;
    start  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      d   = (k < 8) && (k % 2 == 0);
      inj = (m == 2) && (k == 6);
      tick();
      start = 1'b0;
    end
    inj  = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  initial begin
    // 1: reset with start/d toggling
    rst = 1'b1; start = 1'b1; d = 1'b1;
    tick();
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err_pulse", ep0, 0);
    check("rst_err_count", ec0, 0);
    check("rst_sample_count", sc0, 0);
    check("rst_first_err", fe0, 0);
    start = 1'b0; d = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // 2: ideal DUT
    run_window(0);
    check("ideal_done", done0, 1);
    check("ideal_pass", pass0, 1);
    check("ideal_samples", sc0, 8);
    check("ideal_errs", ec0, 0);
    check("ideal_pulses", pulses, 0);

    // 3: q stuck at 0
    run_window(1);
    check("stuck_errs", ec0, 4);
    check("stuck_first", fe0, 0);
    check("stuck_pulses", pulses, 4);
    check("stuck_pass", pass0, 0);
    check("stuck_samples", sc0, 8);

    // 4: qn == q on sample 5 only
    run_window(2);
    check("qn_errs", ec0, 1);
    check("qn_first", fe0, 5);
    check("qn_pulses", pulses, 1);
    check("qn_pass", pass0, 0);
    mode = 0;

    // 5: saturation with CNT_W=4, every sample mismatching
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("sat_samples", sc1, 15);
    check("sat_errs", ec1, 15);
    check("sat_first", fe1, 0);
    check("sat_done", done1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy", busy1, 1);
    check("restart_samples", sc1, 0);
    check("restart_errs", ec1, 0);
    check("restart_done", done1, 0);

    // 6: LATENCY=3 against a 3-stage ideal DUT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1; d = pat6[0];
    tick();
    start = 1'b0;
    check("lat3_busy", busy2, 1);
    check("lat3_e0_samples", sc2, 0);
    for (int k = 1; k <= 12; k++) begin
      d     = pat6[k];
      start = (k == 7);
      tick();
      if (k <= 3) check($sformatf("lat3_e%0d_samples", k), sc2, (k == 3) ? 1 : 0);
      if (k == 7) check("lat3_midstart_samples", sc2, 5);
      if (k == 7) check("lat3_midstart_busy", busy2, 1);
    end
    start = 1'b0;
    check("lat3_samples", sc2, 10);
    check("lat3_errs", ec2, 0);
    check("lat3_err_pulse", ep2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy2, 0);
    check("midrst_done", done2, 0);
    check("midrst_samples", sc2, 0);
    check("midrst_errs", ec2, 0);
    start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("fillstop_done", done2, 1);
    check("fillstop_samples", sc2, 0);
    check("fillstop_pass", pass2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
